trace_exec_tx: RTL and testbench
================================

# trace_exec_tx

Transmitter side of the execution-trace path. Captures the per-core exec trace (enable, pc, insn, writeback) each cycle, buffers records in a small FIFO and serializes them into 16-bit flits over a valid/ready link toward a remote trace monitor. It sits in the compute tile beside the core, replacing the wide parallel trace bus with a narrow stream. On buffer overflow it drops records and reports the drop count in-band, in order.

## Interface
- `ID`, 0: core identifier, 8 bit, placed in every header flit
- `FIFO_DEPTH`, 4: record buffer depth, power of two, ≥2
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `trace_enable` in 1: instruction retired this cycle
- `trace_pc` in 32: retired PC
- `trace_insn` in 32: retired instruction word
- `trace_wben` in 1: writeback valid
- `trace_wbreg` in 5: writeback register
- `trace_wbdata` in 32: writeback data
- `out_flit` out 16: flit data
- `out_valid` out 1: flit valid
- `out_last` out 1: last flit of record
- `out_ready` in 1: sink accepts flit
- `drop_cnt` out 14: current pending drop count (status)

## Operation
- Exec record header: [15:14]=2'b00, [13]=wben, [12:8]=wbreg, [7:0]=ID. Then pc[31:16], pc[15:0], insn[31:16], insn[15:0]; if wben, also wbdata[31:16], wbdata[15:0]. Length 5 or 7 flits.
- Overflow record: single flit, [15:14]=2'b01, [13:0]=dropped count; out_last=1.
- Push: trace_enable=1, FIFO not full, drop_cnt=0 → record stored.
- Drop: trace_enable=1 and (FIFO full or drop_cnt≠0) → record discarded, drop_cnt+1, saturating at 14'h3FFF. Full uses registered state; a same-cycle pop does not make room for a same-cycle push.
- Once dropping starts, pushes stay blocked until the FIFO drains and the overflow record is sent; the marker therefore appears exactly where the lost records belong.
- FSM states: IDLE, HDR, PC_HI, PC_LO, IN_HI, IN_LO, WB_HI, WB_LO, OVF.
  - IDLE: FIFO non-empty → HDR; else drop_cnt≠0 → OVF.
  - Each non-IDLE state advances on out_valid&out_ready.
  - IN_LO → WB_HI if head.wben, else IDLE with head pop.
  - WB_LO → IDLE with pop.
  - OVF → IDLE; drop_cnt cleared in that handshake cycle. A drop in the same cycle restarts the count at 1.
- out_valid=1 in every non-IDLE state. out_flit and out_last are stable while valid&!ready.

## Timing
- Reset: FSM IDLE, FIFO empty, drop_cnt=0, out_valid=0, out_last=0, out_flit=0.
- Latency: record pushed in cycle N into an empty, idle block → header valid in cycle N+1.
- Throughput: one flit per cycle under ready=1. Back-to-back records have one IDLE bubble cycle between them.
- Reset asserted mid-record: the record is abandoned immediately and the FIFO is cleared. The sink must discard the partial record (no out_last was seen).

## Configuration
- `TRACE_EXEC_TX_WBDATA_EN` defined: header carries wben/wbreg, and WB_HI/WB_LO flits are sent when wben=1.
- Undefined: header [13:8]=0, records are always 5 flits, wbdata/wbreg are not stored (FIFO entry 64 bits instead of 102).

## Structure
- Package `trace_tx_pkg`: flit type codes (TYPE_EXEC=2'b00, TYPE_OVF=2'b01), FSM state enum, record struct (pc, insn, wben, wbreg, wbdata), DROP_CNT_W=14.
- Sub-module `trace_tx_fifo`: synchronous FIFO parameterized on width and depth, with push/pop/full/empty ports.

## Test plan
- Single record pc=0x0000_2000, insn=0x1500_0000, wben=0, ready=1 → flits 0x00|ID, 0x0000, 0x2000, 0x1500, 0x0000; out_last on 5th.
- wben=1, wbreg=3, wbdata=0xDEAD_BEEF (macro on) → header 0x2300|ID, 7 flits, last two 0xDEAD, 0xBEEF. Macro off → header 0x0000|ID, 5 flits.
- Backpressure: ready toggles 1,0,0,1 → each flit held stable, no loss, no duplication.
- Overflow, FIFO_DEPTH=4, ready=0, 10 consecutive retires, then ready=1 → 4 exec records, then overflow flit 0x4006. A following retire is emitted after the overflow flit.
- Saturation: 20000 drops → overflow flit 0x7FFF.
- Reset during PC_LO → outputs return to reset values next edge. A new record after release is emitted complete.

Source files
------------

// File: rtl/trace_tx_pkg.sv
// Shared types and constants for the execution-trace transmitter.
// The optional TRACE_EXEC_TX_WBDATA_EN build stores and sends writeback data.
package trace_tx_pkg;

    localparam int DROP_CNT_W = 14;

    localparam logic [1:0] TYPE_EXEC = 2'b00;
    localparam logic [1:0] TYPE_OVF  = 2'b01;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        PC_HI,
        PC_LO,
        IN_HI,
        IN_LO,
        WB_HI,
        WB_LO,
        OVF
    } tx_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
    } trace_rec_t;

    // Record width when only pc and insn are buffered.
    localparam int REC_SHORT_W = 64;

endpackage

// File: rtl/trace_tx_fifo.sv
// Synchronous record FIFO with registered pointers; storage is not reset,
// only the pointers are. DEPTH must be a power of two.
module trace_tx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/trace_exec_tx.sv
// Execution-trace transmitter: buffers retire records and streams them as 16-bit flits.
// Define TRACE_EXEC_TX_WBDATA_EN to carry wben/wbreg in the header and append wbdata flits.
module trace_exec_tx
    import trace_tx_pkg::*;
#(
    parameter logic [7:0] ID         = 8'd0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trace_enable,
    input  logic [31:0]           trace_pc,
    input  logic [31:0]           trace_insn,
    input  logic                  trace_wben,
    input  logic [4:0]            trace_wbreg,
    input  logic [31:0]           trace_wbdata,
    output logic [15:0]           out_flit,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

`ifdef TRACE_EXEC_TX_WBDATA_EN
    localparam int REC_W = $bits(trace_rec_t);
`else
    localparam int REC_W = REC_SHORT_W;
`endif

    tx_state_e             state;
    tx_state_e             state_nxt;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_nxt;
    logic [DROP_CNT_W-1:0] ovf_cnt_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  hs;
    logic [REC_W-1:0]      fifo_din;
    logic [REC_W-1:0]      fifo_dout;
    trace_rec_t            head;

    function automatic logic [DROP_CNT_W-1:0] drop_cnt_sat_add(
        input logic [DROP_CNT_W-1:0] base,
        input logic                  inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, base} + {{DROP_CNT_W{1'b0}}, inc};
        return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
    endfunction

    // Full and drop_cnt are registered; a pop this cycle never frees room for this push.
    assign push = trace_enable && !fifo_full && (drop_cnt_q == '0);
    assign drop = trace_enable && !push;

    always_comb begin
        fifo_din = '0;
`ifdef TRACE_EXEC_TX_WBDATA_EN
        fifo_din = {trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata};
`else
        fifo_din = {trace_pc, trace_insn};
`endif
    end

`ifndef TRACE_EXEC_TX_WBDATA_EN
    logic unused_wb;
    assign unused_wb = ^{trace_wben, trace_wbreg, trace_wbdata};
`endif

    trace_tx_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        head      = '0;
`ifdef TRACE_EXEC_TX_WBDATA_EN
        head      = trace_rec_t'(fifo_dout);
`else
        head.pc   = fifo_dout[63:32];
        head.insn = fifo_dout[31:0];
`endif
    end

    assign out_valid = (state != IDLE);
    assign hs        = out_valid && out_ready;
    assign drop_cnt  = drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            state      <= state_nxt;
            drop_cnt_q <= drop_cnt_nxt;
            if (state == IDLE && state_nxt == OVF) ovf_cnt_q <= drop_cnt_q;
        end
    end

    // The overflow flit shows the count latched on entry so it stays stable under
    // backpressure; drops that arrive while it waits remain pending for a later marker.
    always_comb begin
        drop_cnt_nxt = drop_cnt_q;
        if (hs && state == OVF) begin
            drop_cnt_nxt = drop_cnt_sat_add(drop_cnt_q - ovf_cnt_q, drop);
        end else if (drop) begin
            drop_cnt_nxt = drop_cnt_sat_add(drop_cnt_q, 1'b1);
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        out_flit  = '0;
        out_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty || push) state_nxt = HDR;
                else if (drop_cnt_q != '0) state_nxt = OVF;
            end
            HDR: begin
                out_flit = {TYPE_EXEC, head.wben, head.wbreg, ID};
                if (hs) state_nxt = PC_HI;
            end
            PC_HI: begin
                out_flit = head.pc[31:16];
                if (hs) state_nxt = PC_LO;
            end
            PC_LO: begin
                out_flit = head.pc[15:0];
                if (hs) state_nxt = IN_HI;
            end
            IN_HI: begin
                out_flit = head.insn[31:16];
                if (hs) state_nxt = IN_LO;
            end
            IN_LO: begin
                out_flit = head.insn[15:0];
                out_last = !head.wben;
                if (hs) begin
                    if (head.wben) begin
                        state_nxt = WB_HI;
                    end else begin
                        state_nxt = IDLE;
                        pop       = 1'b1;
                    end
                end
            end
            WB_HI: begin
                out_flit = head.wbdata[31:16];
                if (hs) state_nxt = WB_LO;
            end
            WB_LO: begin
                out_flit = head.wbdata[15:0];
                out_last = 1'b1;
                if (hs) begin
                    state_nxt = IDLE;
                    pop       = 1'b1;
                end
            end
            OVF: begin
                out_flit = {TYPE_OVF, ovf_cnt_q};
                out_last = 1'b1;
                if (hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trace_exec_tx.sv
// Self-checking bench for trace_exec_tx: queue-based flit model plus directed literal checks.
// Honours TRACE_EXEC_TX_WBDATA_EN when defined for the build.
`timescale 1ns/1ps
module tb_trace_exec_tx;

    localparam logic [7:0] ID    = 8'h5A;
    localparam int         DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
    } rec_s;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_enable = 1'b0;
    logic [31:0] trace_pc = '0;
    logic [31:0] trace_insn = '0;
    logic        trace_wben = 1'b0;
    logic [4:0]  trace_wbreg = '0;
    logic [31:0] trace_wbdata = '0;
    logic [15:0] out_flit;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic [13:0] drop_cnt;

    always #5 clk = ~clk;

    trace_exec_tx #(.ID(ID), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_enable (trace_enable),
        .trace_pc     (trace_pc),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .drop_cnt     (drop_cnt)
    );

    // Model: records held in the buffer, flits of the record on the wire, pending drops.
    rec_s        recq[$];
    logic [16:0] txq[$];
    bit          tx_ovf;
    int          ovf_val;
    int          dcnt;
    logic [15:0] got[$];
    bit          got_last[$];
    int          total = 0;
    int          passed = 0;
    rec_s        zero_rec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        recq.delete();
        txq.delete();
        tx_ovf  = 0;
        ovf_val = 0;
        dcnt    = 0;
    endtask

    task automatic load_rec(input rec_s r);
        bit wb;
        logic [15:0] h;
`ifdef TRACE_EXEC_TX_WBDATA_EN
        wb = r.wben;
        h  = {2'b00, r.wben, r.wbreg, ID};
`else
        wb = 0;
        h  = {8'h00, ID};
`endif
        txq.push_back({1'b0, h});
        txq.push_back({1'b0, r.pc[31:16]});
        txq.push_back({1'b0, r.pc[15:0]});
        txq.push_back({1'b0, r.insn[31:16]});
        txq.push_back({!wb, r.insn[15:0]});
        if (wb) begin
            txq.push_back({1'b0, r.wbdata[31:16]});
            txq.push_back({1'b1, r.wbdata[15:0]});
        end
        tx_ovf = 0;
    endtask

    task automatic model_step(input bit en, input bit rdy, input rec_s r);
        bit idle, hs, push, drop;
        int old_d;
        idle  = (txq.size() == 0);
        hs    = !idle && rdy;
        push  = en && (recq.size() < DEPTH) && (dcnt == 0);
        drop  = en && !push;
        old_d = dcnt;
        if (hs) begin
            void'(txq.pop_front());
            if (txq.size() == 0) begin
                if (tx_ovf) dcnt = dcnt - ovf_val;
                else void'(recq.pop_front());
            end
        end
        if (drop) dcnt = (dcnt >= 16383) ? 16383 : dcnt + 1;
        if (push) recq.push_back(r);
        if (idle) begin
            if (recq.size() != 0) begin
                load_rec(recq[0]);
            end else if (old_d != 0) begin
                txq.push_back({1'b1, 2'b01, 14'(old_d)});
                tx_ovf  = 1;
                ovf_val = old_d;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [16:0] e;
        e = (txq.size() != 0) ? txq[0] : 17'h0;
        check("out_valid", 32'(out_valid), 32'(txq.size() != 0));
        check("out_flit", 32'(out_flit), 32'(e[15:0]));
        check("out_last", 32'(out_last), 32'(e[16]));
        check("drop_cnt", 32'(drop_cnt), 32'(dcnt));
    endtask

    task automatic cyc(input bit en, input bit rdy, input rec_s r);
        @(negedge clk);
        compare_outputs();
        #1;
        trace_enable = en;
        out_ready    = rdy;
        trace_pc     = r.pc;
        trace_insn   = r.insn;
        trace_wben   = r.wben;
        trace_wbreg  = r.wbreg;
        trace_wbdata = r.wbdata;
        #1;
        if (out_valid && out_ready) begin
            got.push_back(out_flit);
            got_last.push_back(out_last);
        end
        @(posedge clk);
        model_step(en, rdy, r);
    endtask

    task automatic drain(input string name);
        int idle_n;
        idle_n = 0;
        for (int i = 0; i < 400 && idle_n < 2; i++) begin
            cyc(0, 1, zero_rec);
            if (txq.size() == 0 && recq.size() == 0 && dcnt == 0) idle_n++;
            else idle_n = 0;
        end
        check(name, 32'(idle_n >= 2), 32'd1);
    endtask

    function automatic rec_s mk(input logic [31:0] pc, input logic [31:0] insn, input logic wben,
                                input logic [4:0] wbreg, input logic [31:0] wbdata);
        rec_s r;
        r.pc = pc; r.insn = insn; r.wben = wben; r.wbreg = wbreg; r.wbdata = wbdata;
        return r;
    endfunction

    function automatic rec_s rand_rec();
        return mk($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
    endfunction

    initial begin
        rec_s r1, r2, rw;
        zero_rec = mk(0, 0, 0, 0, 0);
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_flit", 32'(out_flit), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        #1 rst_n = 1'b1;

        // Single record, latency and content
        got.delete(); got_last.delete();
        r1 = mk(32'h0000_2000, 32'h1500_0000, 1'b0, 5'd0, 32'd0);
        cyc(1, 1, r1);
        #1;
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_hdr", 32'(out_flit), 32'h005A);
        drain("drain_single");
        check("single_len", 32'(got.size()), 32'd5);
        if (got.size() == 5) begin
            check("single_f0", 32'(got[0]), 32'h005A);
            check("single_f1", 32'(got[1]), 32'h0000);
            check("single_f2", 32'(got[2]), 32'h2000);
            check("single_f3", 32'(got[3]), 32'h1500);
            check("single_f4", 32'(got[4]), 32'h0000);
            check("single_last4", 32'(got_last[4]), 32'd1);
            check("single_last3", 32'(got_last[3]), 32'd0);
        end

        // Writeback record
        got.delete(); got_last.delete();
        rw = mk(32'h0000_4000, 32'h0000_0013, 1'b1, 5'd3, 32'hDEAD_BEEF);
        cyc(1, 1, rw);
        drain("drain_wb");
`ifdef TRACE_EXEC_TX_WBDATA_EN
        check("wb_len", 32'(got.size()), 32'd7);
        if (got.size() == 7) begin
            check("wb_hdr", 32'(got[0]), 32'h235A);
            check("wb_hi", 32'(got[5]), 32'hDEAD);
            check("wb_lo", 32'(got[6]), 32'hBEEF);
            check("wb_last", 32'(got_last[6]), 32'd1);
        end
`else
        check("wb_len", 32'(got.size()), 32'd5);
        if (got.size() == 5) begin
            check("wb_hdr", 32'(got[0]), 32'h005A);
            check("wb_last", 32'(got_last[4]), 32'd1);
        end
`endif

        // Backpressure with ready pattern 1,0,0,1
        got.delete(); got_last.delete();
        r2 = mk(32'hCAFE_0004, 32'h0041_0113, 1'b0, 5'd0, 32'd0);
        cyc(1, 1, r2);
        for (int i = 0; i < 24; i++) cyc(0, (i % 4 == 0) || (i % 4 == 3), zero_rec);
        drain("drain_bp");
        check("bp_len", 32'(got.size()), 32'd5);
        if (got.size() == 5) begin
            check("bp_f1", 32'(got[1]), 32'hCAFE);
            check("bp_f2", 32'(got[2]), 32'h0004);
            check("bp_f3", 32'(got[3]), 32'h0041);
            check("bp_f4", 32'(got[4]), 32'h0113);
        end

        // Overflow: 10 retires with ready low, then drain, then one more retire
        got.delete(); got_last.delete();
        for (int k = 0; k < 10; k++) cyc(1, 0, mk(32'h100 + 32'(k) * 4, 32'(k), 1'b0, 5'd0, 32'd0));
        #1 check("ovf_drop_cnt", 32'(drop_cnt), 32'd6);
        drain("drain_ovf");
        cyc(1, 1, mk(32'h0000_0200, 32'h0000_0077, 1'b0, 5'd0, 32'd0));
        drain("drain_after_ovf");
        check("ovf_len", 32'(got.size()), 32'd26);
        if (got.size() == 26) begin
            check("ovf_r0_pclo", 32'(got[2]), 32'h0100);
            check("ovf_r3_pclo", 32'(got[17]), 32'h010C);
            check("ovf_flit", 32'(got[20]), 32'h4006);
            check("ovf_last", 32'(got_last[20]), 32'd1);
            check("ovf_next_hdr", 32'(got[21]), 32'h005A);
            check("ovf_next_insn", 32'(got[25]), 32'h0077);
        end

        // Saturation: 4 stored, 20000 dropped
        got.delete(); got_last.delete();
        for (int k = 0; k < 20004; k++) cyc(1, 0, mk($urandom, $urandom, 1'b0, 5'd0, 32'd0));
        #1 check("sat_drop_cnt", 32'(drop_cnt), 32'h3FFF);
        drain("drain_sat");
        check("sat_len", 32'(got.size()), 32'd21);
        if (got.size() == 21) check("sat_flit", 32'(got[20]), 32'h7FFF);

        // Reset while in PC_LO
        got.delete(); got_last.delete();
        cyc(1, 1, r2);
        cyc(0, 1, zero_rec);
        cyc(0, 1, zero_rec);
        #1 check("pre_rst_pclo", 32'(out_flit), 32'h0004);
        @(negedge clk);
        compare_outputs();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_flit", 32'(out_flit), 32'd0);
        check("midrst_last", 32'(out_last), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        got.delete(); got_last.delete();
        cyc(1, 1, r1);
        drain("drain_post_rst");
        check("postrst_len", 32'(got.size()), 32'd5);
        if (got.size() == 5) begin
            check("postrst_hdr", 32'(got[0]), 32'h005A);
            check("postrst_pclo", 32'(got[2]), 32'h2000);
            check("postrst_last", 32'(got_last[4]), 32'd1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), rand_rec());
        end
        drain("drain_random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
